// File: rtl/rr_lane_scheduler_if.sv
// Lane bundle between four FWFT source FIFOs, the scheduler and the destination.
// The master side is the scheduler; the slave side is the source/destination environment.
interface rr_lane_scheduler_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in_0;
  logic [DATA_W-1:0] data_in_1;
  logic [DATA_W-1:0] data_in_2;
  logic [DATA_W-1:0] data_in_3;
  logic [3:0]        fifo_empty;
  logic              dest_almost_full;
  logic [3:0]        pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [1:0]        grant_id;
  logic              active;

  modport master (
    input  data_in_0, data_in_1, data_in_2, data_in_3, fifo_empty, dest_almost_full,
    output pop, data_out, valid_out, grant_id, active
  );

  modport slave (
    output data_in_0, data_in_1, data_in_2, data_in_3, fifo_empty, dest_almost_full,
    input  pop, data_out, valid_out, grant_id, active
  );
endinterface

// File: rtl/rr_lane_scheduler.sv
// Round-robin burst scheduler sharing one registered data lane among four FWFT FIFOs.
// Pop is combinational; popped word appears on the lane one cycle later; dest_almost_full stalls the grant in place.
module rr_lane_scheduler #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                clk_f,
  input  logic                reset,
  rr_lane_scheduler_if.master lane
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [1:0]        grant_id;
  logic [CNT_W-1:0]  burst_cnt;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              active_q;

  logic [3:0]        pop_c;
  logic              popping;
  logic [1:0]        winner;
  logic              any_req;
  logic              burst_done;
  logic              rearb;
  logic [DATA_W-1:0] head;

  always_comb begin
    head = lane.data_in_0;
    case (grant_id)
      2'd0: head = lane.data_in_0;
      2'd1: head = lane.data_in_1;
      2'd2: head = lane.data_in_2;
      2'd3: head = lane.data_in_3;
      default: head = lane.data_in_0;
    endcase
  end

  // Scan from farthest to nearest so the source right after grant_id wins; current grantee is last.
  always_comb begin
    winner = grant_id;
    for (int k = 4; k >= 1; k--) begin
      if (!lane.fifo_empty[grant_id + 2'(k)]) winner = grant_id + 2'(k);
    end
  end

  assign any_req = ~&lane.fifo_empty;

  always_comb begin
    pop_c = '0;
    if (!reset && state == GRANT && !lane.fifo_empty[grant_id] && !lane.dest_almost_full)
      pop_c[grant_id] = 1'b1;
  end

  assign popping    = |pop_c;
  assign burst_done = (burst_cnt == CNT_W'(MAX_BURST - 1));
  // A stall (backpressure on a non-empty source) never re-arbitrates.
  assign rearb      = (popping && burst_done) || (!popping && lane.fifo_empty[grant_id]);

  always_ff @(posedge clk_f) begin
    if (reset) begin
      state     <= IDLE;
      grant_id  <= 2'd3;
      burst_cnt <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      valid_q <= popping;
      if (popping) data_q <= head;

      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id  <= winner;
            burst_cnt <= '0;
            state     <= GRANT;
            active_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (rearb) begin
            if (any_req) begin
              grant_id  <= winner;
              burst_cnt <= '0;
            end else begin
              state    <= IDLE;
              active_q <= 1'b0;
            end
          end else if (popping) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign lane.pop       = pop_c;
  assign lane.data_out  = data_q;
  assign lane.valid_out = valid_q;
  assign lane.grant_id  = grant_id;
  assign lane.active    = active_q;

endmodule

// File: tb/tb_rr_lane_scheduler.sv
// Directed bench for rr_lane_scheduler: FWFT FIFO models as queues, cycle table plus corner sequences.
module tb_rr_lane_scheduler;

  logic clk_f = 1'b0;
  logic reset;

  always #5 clk_f = ~clk_f;

  rr_lane_scheduler_if #(.DATA_W(8)) bus ();

  rr_lane_scheduler #(.DATA_W(8), .MAX_BURST(4), .CNT_W(3)) dut (
    .clk_f (clk_f),
    .reset (reset),
    .lane  (bus)
  );

  typedef struct {
    logic       rst;
    logic       afull;
    int         ld_src;
    int         ld_n;
    logic [3:0] pop;
    logic       vld;
    logic [7:0] dat;
    logic [1:0] gid;
    logic       act;
  } vec_t;

  vec_t tbl [20];

  logic [7:0] q0[$], q1[$], q2[$], q3[$];
  int         nxt [4];
  logic [3:0] pop_s;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] rx[$];
  int         rx_cyc[$];

  always @(posedge clk_f) cyc <= cyc + 1;

  always @(negedge clk_f) begin
    if (mon_en && bus.valid_out) begin
      rx.push_back(bus.data_out);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    bus.fifo_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    bus.data_in_0  = (q0.size() != 0) ? q0[0] : 8'h00;
    bus.data_in_1  = (q1.size() != 0) ? q1[0] : 8'h00;
    bus.data_in_2  = (q2.size() != 0) ? q2[0] : 8'h00;
    bus.data_in_3  = (q3.size() != 0) ? q3[0] : 8'h00;
  endtask

  task automatic load(input int src, input int n);
    logic [7:0] w;
    for (int j = 0; j < n; j++) begin
      w = 8'((src << 5) | nxt[src]);
      nxt[src]++;
      case (src)
        0: q0.push_back(w);
        1: q1.push_back(w);
        2: q2.push_back(w);
        default: q3.push_back(w);
      endcase
    end
  endtask

  // Move to the next cycle: pops seen before the edge leave the FIFO models just after it.
  task automatic adv();
    #1;
    pop_s = bus.pop;
    @(posedge clk_f);
    #1;
    if (pop_s[0] && q0.size() != 0) void'(q0.pop_front());
    if (pop_s[1] && q1.size() != 0) void'(q1.pop_front());
    if (pop_s[2] && q2.size() != 0) void'(q2.pop_front());
    if (pop_s[3] && q3.size() != 0) void'(q3.pop_front());
    drive();
  endtask

  task automatic run_idle(input int n, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      adv();
      @(negedge clk_f);
      #1;
      if (rx.size() >= n && !bus.active) done = 1'b1;
    end
    chk("run_to_idle", 32'(done), 32'd1);
  endtask

  function automatic int gaps();
    if (rx_cyc.size() == 0) return -1;
    return rx_cyc[rx_cyc.size()-1] - rx_cyc[0] + 1 - rx.size();
  endfunction

  task automatic clr_rx();
    rx.delete();
    rx_cyc.delete();
    for (int s = 0; s < 4; s++) nxt[s] = 1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, -1, 0, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0};
    tbl[1]  = '{1'b0, 1'b0,  2, 3, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, -1, 0, 4'h4, 1'b0, 8'h00, 2'd2, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, -1, 0, 4'h4, 1'b1, 8'h41, 2'd2, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, -1, 0, 4'h4, 1'b1, 8'h42, 2'd2, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, -1, 0, 4'h0, 1'b1, 8'h43, 2'd2, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, -1, 0, 4'h0, 1'b0, 8'h43, 2'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, -1, 0, 4'h0, 1'b0, 8'h43, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0,  1, 6, 4'h0, 1'b0, 8'h43, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, -1, 0, 4'h2, 1'b0, 8'h43, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, -1, 0, 4'h2, 1'b1, 8'h21, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, -1, 0, 4'h0, 1'b1, 8'h22, 2'd1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, -1, 0, 4'h0, 1'b0, 8'h22, 2'd1, 1'b1};
    tbl[13] = '{1'b0, 1'b1, -1, 0, 4'h0, 1'b0, 8'h22, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, -1, 0, 4'h2, 1'b0, 8'h22, 2'd1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, -1, 0, 4'h2, 1'b1, 8'h23, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, -1, 0, 4'h2, 1'b1, 8'h24, 2'd1, 1'b1};
    tbl[17] = '{1'b0, 1'b0, -1, 0, 4'h2, 1'b1, 8'h25, 2'd1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, -1, 0, 4'h0, 1'b1, 8'h26, 2'd1, 1'b1};
    tbl[19] = '{1'b0, 1'b0, -1, 0, 4'h0, 1'b0, 8'h26, 2'd1, 1'b0};

    for (int s = 0; s < 4; s++) nxt[s] = 1;
    reset = 1'b1;
    bus.dest_almost_full = 1'b0;
    drive();
    repeat (3) @(posedge clk_f);

    // Single-source drain, then a backpressured burst on source 1.
    for (int i = 0; i < 20; i++) begin
      adv();
      reset = tbl[i].rst;
      bus.dest_almost_full = tbl[i].afull;
      if (tbl[i].ld_src >= 0) load(tbl[i].ld_src, tbl[i].ld_n);
      drive();
      @(negedge clk_f);
      chk($sformatf("v%0d.pop", i),   32'(bus.pop),       32'(tbl[i].pop));
      chk($sformatf("v%0d.vld", i),   32'(bus.valid_out), 32'(tbl[i].vld));
      chk($sformatf("v%0d.dat", i),   32'(bus.data_out),  32'(tbl[i].dat));
      chk($sformatf("v%0d.gid", i),   32'(bus.grant_id),  32'(tbl[i].gid));
      chk($sformatf("v%0d.act", i),   32'(bus.active),    32'(tbl[i].act));
    end

    // Reset lands while source 3 is mid-burst.
    adv(); load(3, 3); drive();
    @(negedge clk_f);
    adv(); @(negedge clk_f);
    chk("rst.gid_b", 32'(bus.grant_id), 32'd3);
    chk("rst.pop_b", 32'(bus.pop), 32'h8);
    adv(); @(negedge clk_f);
    chk("rst.pop_c", 32'(bus.pop), 32'h8);
    chk("rst.dat_c", 32'(bus.data_out), 32'h61);
    adv(); reset = 1'b1; load(0, 2); drive();
    @(negedge clk_f);
    chk("rst.pop_forced", 32'(bus.pop), 32'h0);
    chk("rst.dat_d", 32'(bus.data_out), 32'h62);
    adv(); reset = 1'b0; drive();
    @(negedge clk_f);
    chk("rst.vld", 32'(bus.valid_out), 32'd0);
    chk("rst.dat", 32'(bus.data_out), 32'h00);
    chk("rst.gid", 32'(bus.grant_id), 32'd3);
    chk("rst.act", 32'(bus.active), 32'd0);
    chk("rst.q3_kept", 32'(q3.size()), 32'd1);
    adv(); @(negedge clk_f);
    chk("rst.prio_gid", 32'(bus.grant_id), 32'd0);
    chk("rst.prio_pop", 32'(bus.pop), 32'h1);
    repeat (3) adv();
    @(negedge clk_f);
    chk("rst.resume_gid", 32'(bus.grant_id), 32'd3);
    chk("rst.resume_pop", 32'(bus.pop), 32'h8);
    adv(); @(negedge clk_f);
    chk("rst.last_dat", 32'(bus.data_out), 32'h63);
    chk("rst.last_vld", 32'(bus.valid_out), 32'd1);
    adv(); @(negedge clk_f);
    chk("rst.idle", 32'(bus.active), 32'd0);

    // All four sources loaded with eight words each.
    clr_rx();
    adv();
    for (int s = 0; s < 4; s++) load(s, 8);
    drive();
    mon_en = 1'b1;
    run_idle(32, 100);
    chk("all4.count", 32'(rx.size()), 32'd32);
    chk("all4.gaps", 32'(gaps()), 32'd0);
    for (int j = 0; j < 32 && j < rx.size(); j++)
      chk($sformatf("all4.w%0d", j), 32'(rx[j]),
          32'((((j % 16) / 4) << 5) | ((j / 16) * 4 + (j % 4) + 1)));

    // Lone source re-granted after every burst with no idle gap.
    mon_en = 1'b0;
    clr_rx();
    adv(); load(0, 10); drive();
    mon_en = 1'b1;
    run_idle(10, 40);
    chk("solo.count", 32'(rx.size()), 32'd10);
    chk("solo.gaps", 32'(gaps()), 32'd0);
    for (int j = 0; j < 10 && j < rx.size(); j++)
      chk($sformatf("solo.w%0d", j), 32'(rx[j]), 32'(j + 1));
    chk("solo.gid", 32'(bus.grant_id), 32'd0);

    // Source 0 drains early; switch to source 2 costs one bubble.
    mon_en = 1'b0;
    adv(); reset = 1'b1; drive();
    @(negedge clk_f);
    clr_rx();
    adv(); reset = 1'b0; load(0, 2); load(2, 3); drive();
    mon_en = 1'b1;
    @(negedge clk_f);
    chk("sw.gid0", 32'(bus.grant_id), 32'd3);
    adv(); @(negedge clk_f);
    chk("sw.gid1", 32'(bus.grant_id), 32'd0);
    chk("sw.pop1", 32'(bus.pop), 32'h1);
    adv();
    adv(); @(negedge clk_f);
    chk("sw.pop3", 32'(bus.pop), 32'h0);
    adv(); @(negedge clk_f);
    chk("sw.gid4", 32'(bus.grant_id), 32'd2);
    chk("sw.pop4", 32'(bus.pop), 32'h4);
    run_idle(5, 20);
    chk("sw.count", 32'(rx.size()), 32'd5);
    chk("sw.gaps", 32'(gaps()), 32'd1);
    if (rx.size() == 5) begin
      chk("sw.w0", 32'(rx[0]), 32'h01);
      chk("sw.w1", 32'(rx[1]), 32'h02);
      chk("sw.w2", 32'(rx[2]), 32'h41);
      chk("sw.w4", 32'(rx[4]), 32'h43);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
